// File: rtl/term_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : term_engine
//  Purpose  : Byte-stream terminal engine. Accepts received bytes, keeps a
//             cursor, decodes a subset of ANSI/VT100 escape sequences and
//             issues fill/copy commands to an external text-buffer blitter.
//  Revision : 1.0  initial release
//
//  Ports
//    clk100       in   1       clock, all logic on rising edge
//    rst          in   1       asynchronous active-high reset
//    char_in      in   8       received byte
//    char_valid   in   1       one-cycle strobe, char_in valid
//    char_ready   out  1       byte can be accepted this cycle
//    overflow     out  1       one-cycle pulse: byte offered while busy, dropped
//    wr_start     out  1       one-cycle pulse launching a blit/fill
//    wr_begin     out  ADDR_W  first cell of the command range
//    wr_end       out  ADDR_W  one past the last cell of the command range
//    wr_data      out  8       fill byte (used when wr_offset == 0)
//    wr_offset    out  8       nonzero: copy cell[a+offset] into cell[a]
//    wr_complete  in   1       one-cycle strobe, current command finished
//    cur_row      out  6       cursor row, 0-based
//    cur_col      out  7       cursor column, 0-based
// ============================================================================
module term_engine #(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int ADDR_W = 11
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              overflow,
    output logic              wr_start,
    output logic [ADDR_W-1:0] wr_begin,
    output logic [ADDR_W-1:0] wr_end,
    output logic [7:0]        wr_data,
    output logic [7:0]        wr_offset,
    input  logic              wr_complete,
    output logic [5:0]        cur_row,
    output logic [6:0]        cur_col
);

    localparam logic [5:0]        c_LAST_ROW   = 6'(ROWS - 1);
    localparam logic [6:0]        c_LAST_COL   = 7'(COLS - 1);
    localparam logic [ADDR_W-1:0] c_COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] c_SCROLL_END = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] c_SCREEN_END = ADDR_W'(ROWS * COLS);
    localparam logic [7:0]        c_LINE_OFS   = 8'(COLS);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ESC        = 3'd1,
        S_CSI        = 3'd2,
        S_WAIT       = 3'd3,
        S_SCROLL_CLR = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        row_q, row_d;
    logic [6:0]        col_q, col_d;
    logic [7:0]        p1_q, p1_d;
    logic [7:0]        p2_q, p2_d;
    logic              idx_q, idx_d;
    // A character write that wrapped on the last row still owes a scroll.
    logic              pend_q, pend_d;
    logic              wr_start_q, wr_start_d;
    logic [ADDR_W-1:0] wr_begin_q, wr_begin_d;
    logic [ADDR_W-1:0] wr_end_q, wr_end_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        wr_offset_q, wr_offset_d;
    logic              overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_ready;
    logic              w_accept;
    logic [ADDR_W-1:0] w_row_start;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_p1_eff, w_p2_eff;
    logic [7:0]        w_p1_m1, w_p2_m1;
    logic [7:0]        w_digit;
    logic [7:0]        w_p_sel;
    logic [11:0]       w_p_acc;
    logic [7:0]        w_p_next;
    logic              w_is_digit;
    logic [5:0]        w_up_row, w_dn_row, w_h_row;
    logic [6:0]        w_lt_col, w_rt_col, w_h_col, w_tab_col;
    logic [8:0]        w_dn_sum, w_rt_sum;
    logic [7:0]        w_tab;

    assign w_ready  = (state_q == S_IDLE) || (state_q == S_ESC) || (state_q == S_CSI);
    assign w_accept = char_valid && w_ready;

    assign w_row_start = ADDR_W'(row_q) * c_COLS_A;
    assign w_addr      = w_row_start + ADDR_W'(col_q);

    // A zero parameter means "one" for every final that uses it.
    assign w_p1_eff = (p1_q == 8'd0) ? 8'd1 : p1_q;
    assign w_p2_eff = (p2_q == 8'd0) ? 8'd1 : p2_q;
    assign w_p1_m1  = w_p1_eff - 8'd1;
    assign w_p2_m1  = w_p2_eff - 8'd1;

    // Decimal accumulation, saturating at 255.
    assign w_is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign w_digit    = char_in - 8'h30;
    assign w_p_sel    = idx_q ? p2_q : p1_q;
    assign w_p_acc    = 12'(w_p_sel) * 12'd10 + 12'(w_digit);
    assign w_p_next   = (w_p_acc > 12'd255) ? 8'd255 : 8'(w_p_acc);

    // Clamped cursor moves.
    assign w_up_row = (w_p1_eff >= 8'(row_q)) ? 6'd0 : row_q - 6'(w_p1_eff);
    assign w_dn_sum = 9'(row_q) + 9'(w_p1_eff);
    assign w_dn_row = (w_dn_sum > 9'(c_LAST_ROW)) ? c_LAST_ROW : 6'(w_dn_sum);
    assign w_lt_col = (w_p1_eff >= 8'(col_q)) ? 7'd0 : col_q - 7'(w_p1_eff);
    assign w_rt_sum = 9'(col_q) + 9'(w_p1_eff);
    assign w_rt_col = (w_rt_sum > 9'(c_LAST_COL)) ? c_LAST_COL : 7'(w_rt_sum);
    assign w_h_row  = (w_p1_m1 > 8'(c_LAST_ROW)) ? c_LAST_ROW : 6'(w_p1_m1);
    assign w_h_col  = (w_p2_m1 > 8'(c_LAST_COL)) ? c_LAST_COL : 7'(w_p2_m1);

    // Next tab stop is the next multiple of 8 strictly after the cursor.
    assign w_tab     = (8'(col_q) | 8'd7) + 8'd1;
    assign w_tab_col = (w_tab > 8'(c_LAST_COL)) ? c_LAST_COL : 7'(w_tab);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= 6'd0;
            col_q       <= 7'd0;
            p1_q        <= 8'd0;
            p2_q        <= 8'd0;
            idx_q       <= 1'b0;
            pend_q      <= 1'b0;
            wr_start_q  <= 1'b0;
            wr_begin_q  <= '0;
            wr_end_q    <= '0;
            wr_data_q   <= 8'd0;
            wr_offset_q <= 8'd0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            wr_start_q  <= wr_start_d;
            wr_begin_q  <= wr_begin_d;
            wr_end_q    <= wr_end_d;
            wr_data_q   <= wr_data_d;
            wr_offset_q <= wr_offset_d;
            overflow_q  <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Command fields only change when wr_start is
    // launched, so they stay stable for the whole command.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        wr_start_d  = 1'b0;
        wr_begin_d  = wr_begin_q;
        wr_end_d    = wr_end_q;
        wr_data_d   = wr_data_q;
        wr_offset_d = wr_offset_q;
        overflow_d  = char_valid && !w_ready;

        unique case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if ((char_in >= 8'h20) && (char_in != 8'h7F)) begin
                        wr_start_d  = 1'b1;
                        wr_begin_d  = w_addr;
                        wr_end_d    = w_addr + ADDR_W'(1);
                        wr_data_d   = char_in;
                        wr_offset_d = 8'd0;
                        state_d     = S_WAIT;
                        if (col_q == c_LAST_COL) begin
                            col_d = 7'd0;
                            if (row_q < c_LAST_ROW) begin
                                row_d = row_q + 6'd1;
                            end else begin
                                pend_d = 1'b1;
                            end
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (char_in)
                            8'h0D: col_d = 7'd0;
                            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
                            8'h09: col_d = w_tab_col;
                            8'h0A: begin
                                if (row_q < c_LAST_ROW) begin
                                    row_d = row_q + 6'd1;
                                end else begin
                                    wr_start_d  = 1'b1;
                                    wr_begin_d  = '0;
                                    wr_end_d    = c_SCROLL_END;
                                    wr_data_d   = 8'd0;
                                    wr_offset_d = c_LINE_OFS;
                                    state_d     = S_SCROLL_CLR;
                                end
                            end
                            8'h1B:   state_d = S_ESC;
                            default: ;
                        endcase
                    end
                end
            end

            S_ESC: begin
                if (w_accept) begin
                    if (char_in == 8'h5B) begin
                        state_d = S_CSI;
                        p1_d    = 8'd0;
                        p2_d    = 8'd0;
                        idx_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_CSI: begin
                if (w_accept) begin
                    if (w_is_digit) begin
                        if (idx_q) p2_d = w_p_next;
                        else       p1_d = w_p_next;
                    end else if (char_in == 8'h3B) begin
                        idx_d = 1'b1;
                    end else if ((char_in >= 8'h40) && (char_in <= 8'h7E)) begin
                        state_d = S_IDLE;
                        case (char_in)
                            8'h41: row_d = w_up_row;
                            8'h42: row_d = w_dn_row;
                            8'h43: col_d = w_rt_col;
                            8'h44: col_d = w_lt_col;
                            8'h48, 8'h66: begin
                                row_d = w_h_row;
                                col_d = w_h_col;
                            end
                            8'h4B: begin
                                if (p1_q <= 8'd2) begin
                                    wr_start_d  = 1'b1;
                                    wr_data_d   = 8'd0;
                                    wr_offset_d = 8'd0;
                                    state_d     = S_WAIT;
                                    case (p1_q)
                                        8'd0: begin
                                            wr_begin_d = w_addr;
                                            wr_end_d   = w_row_start + c_COLS_A;
                                        end
                                        8'd1: begin
                                            wr_begin_d = w_row_start;
                                            wr_end_d   = w_addr + ADDR_W'(1);
                                        end
                                        default: begin
                                            wr_begin_d = w_row_start;
                                            wr_end_d   = w_row_start + c_COLS_A;
                                        end
                                    endcase
                                end
                            end
                            8'h4A: begin
                                if ((p1_q == 8'd0) || (p1_q == 8'd2)) begin
                                    wr_start_d  = 1'b1;
                                    wr_begin_d  = (p1_q == 8'd0) ? w_addr : '0;
                                    wr_end_d    = c_SCREEN_END;
                                    wr_data_d   = 8'd0;
                                    wr_offset_d = 8'd0;
                                    state_d     = S_WAIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            S_WAIT: begin
                if (wr_complete) begin
                    if (pend_q) begin
                        pend_d      = 1'b0;
                        wr_start_d  = 1'b1;
                        wr_begin_d  = '0;
                        wr_end_d    = c_SCROLL_END;
                        wr_data_d   = 8'd0;
                        wr_offset_d = c_LINE_OFS;
                        state_d     = S_SCROLL_CLR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_SCROLL_CLR: begin
                // Blank the freshly exposed bottom line after the copy.
                if (wr_complete) begin
                    wr_start_d  = 1'b1;
                    wr_begin_d  = c_SCROLL_END;
                    wr_end_d    = c_SCREEN_END;
                    wr_data_d   = 8'd0;
                    wr_offset_d = 8'd0;
                    state_d     = S_WAIT;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign char_ready = w_ready;
    assign overflow   = overflow_q;
    assign wr_start   = wr_start_q;
    assign wr_begin   = wr_begin_q;
    assign wr_end     = wr_end_q;
    assign wr_data    = wr_data_q;
    assign wr_offset  = wr_offset_q;
    assign cur_row    = row_q;
    assign cur_col    = col_q;

endmodule

`default_nettype wire

// File: tb/tb_term_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_term_engine
//  Purpose  : Self-checking bench for term_engine (80x25 screen). Expected
//             blitter commands are queued before stimulus and matched as the
//             DUT launches them; cursor results come from a vector table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_term_engine;

    localparam int COLS   = 80;
    localparam int ROWS   = 25;
    localparam int ADDR_W = 11;

    logic              clk100      = 1'b0;
    logic              rst         = 1'b1;
    logic [7:0]        char_in     = 8'd0;
    logic              char_valid  = 1'b0;
    logic              wr_complete = 1'b0;
    logic              char_ready;
    logic              overflow;
    logic              wr_start;
    logic [ADDR_W-1:0] wr_begin;
    logic [ADDR_W-1:0] wr_end;
    logic [7:0]        wr_data;
    logic [7:0]        wr_offset;
    logic [5:0]        cur_row;
    logic [6:0]        cur_col;

    always #5 clk100 = ~clk100;

    term_engine #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk100      (clk100),
        .rst         (rst),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .overflow    (overflow),
        .wr_start    (wr_start),
        .wr_begin    (wr_begin),
        .wr_end      (wr_end),
        .wr_data     (wr_data),
        .wr_offset   (wr_offset),
        .wr_complete (wr_complete),
        .cur_row     (cur_row),
        .cur_col     (cur_col)
    );

    typedef struct packed {
        logic [10:0] b;
        logic [10:0] e;
        logic [7:0]  d;
        logic [7:0]  o;
    } cmd_t;

    typedef struct {
        logic [95:0] msg;
        int          n;
        int          sr;
        int          sc;
        int          er;
        int          ec;
        bit          cmd;
        cmd_t        c;
    } vec_t;

    cmd_t exp_q[$];
    vec_t vt[$];
    int   n_cmp       = 0;
    int   n_fail      = 0;
    int   n_cmds      = 0;
    bit   outstanding = 1'b0;
    cmd_t held;

    function automatic cmd_t mkc(input int b, input int e, input int d, input int o);
        cmd_t c;
        c.b = 11'(b);
        c.e = 11'(e);
        c.d = 8'(d);
        c.o = 8'(o);
        return c;
    endfunction

    function automatic vec_t mk(input logic [95:0] m, input int n, input int sr, input int sc,
                                input int er, input int ec, input bit cmd,
                                input int b, input int e, input int d);
        vec_t v;
        v.msg = m;
        v.n   = n;
        v.sr  = sr;
        v.sc  = sc;
        v.er  = er;
        v.ec  = ec;
        v.cmd = cmd;
        v.c   = mkc(b, e, d, 0);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Observes every launched command, matches it against the scoreboard and
    // checks that the command fields hold until wr_complete.
    task automatic monitor();
        cmd_t obs;
        cmd_t cmp;
        cmd_t e;
        forever begin
            @(negedge clk100);
            if (rst) begin
                outstanding = 1'b0;
            end else begin
                obs = {wr_begin, wr_end, wr_data, wr_offset};
                if (outstanding) check("cmd_hold", obs, held);
                if (wr_start) begin
                    n_cmds++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_wr_start: got begin=%0d end=%0d data=0x%0h offset=%0d, expected no command",
                                 wr_begin, wr_end, wr_data, wr_offset);
                    end else begin
                        e   = exp_q.pop_front();
                        cmp = obs;
                        // Fill byte is meaningless for a copy command.
                        if (e.o != 8'd0) cmp.d = e.d;
                        check("cmd_fields", cmp, e);
                    end
                    held        = obs;
                    outstanding = 1'b1;
                end
                if (wr_complete) outstanding = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        char_in    = b;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic send_num(input int v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic goto_rc(input int r, input int c);
        send(8'h1B);
        send(8'h5B);
        send_num(r + 1);
        send(8'h3B);
        send_num(c + 1);
        send(8'h48);
    endtask

    task automatic pulse_complete();
        tick();
        wr_complete = 1'b1;
        tick();
        wr_complete = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_cmd(input int target, input string name);
        int i;
        i = 0;
        while ((n_cmds < target) && (i < 30)) begin
            @(negedge clk100);
            i++;
        end
        check({name, "_issued"}, 64'(n_cmds >= target), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   base;
        fork
            monitor();
        join_none

        //        msg                       n  sr sc  er ec cmd  begin end  data
        vt.push_back(mk("A",                    1, 0, 0,  0, 1, 1,   0,    1,   8'h41));
        vt.push_back(mk({8'h1B, "[12;300H"},   9, 0, 0, 11,79, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[K"},         3, 3,10,  3,10, 1, 250,  320,   0));
        vt.push_back(mk({8'h1B, "[2J"},        4, 3,10,  3,10, 1,   0, 2000,   0));
        vt.push_back(mk({8'h1B, "[1K"},        4, 3,10,  3,10, 1, 240,  251,   0));
        vt.push_back(mk({8'h1B, "[2K"},        4, 3,10,  3,10, 1, 240,  320,   0));
        vt.push_back(mk({8'h1B, "[J"},         3, 3,10,  3,10, 1, 250, 2000,   0));
        vt.push_back(mk({8'h1B, "[1J"},        4, 3,10,  3,10, 0,   0,    0,   0));
        vt.push_back(mk(8'h0D,                  1, 3,10,  3, 0, 0,   0,    0,   0));
        vt.push_back(mk(8'h08,                  1, 3,10,  3, 9, 0,   0,    0,   0));
        vt.push_back(mk(8'h08,                  1, 0, 0,  0, 0, 0,   0,    0,   0));
        vt.push_back(mk(8'h09,                  1, 3,10,  3,16, 0,   0,    0,   0));
        vt.push_back(mk(8'h09,                  1, 3,78,  3,79, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[5A"},        4, 3,10,  0,10, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[A"},         3, 3,10,  2,10, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[30B"},       5, 3,10, 24,10, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[2C"},        4, 3,10,  3,12, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[99D"},       5, 3,10,  3, 0, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[0C"},        4, 3,10,  3,11, 0,   0,    0,   0));
        vt.push_back(mk("Z",                    1, 3,79,  4, 0, 1, 319,  320,   8'h5A));
        vt.push_back(mk(8'h0A,                  1, 3,10,  4,10, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "x"},          2, 3,10,  3,10, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[5m"},        4, 3,10,  3,10, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[0;0H"},      6, 3,10,  0, 0, 0,   0,    0,   0));
        vt.push_back(mk(8'h7F,                  1, 3,10,  3,10, 0,   0,    0,   0));
        vt.push_back(mk(8'h01,                  1, 3,10,  3,10, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[999;2H"},    8, 3,10, 24, 1, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[1;2;5H"},    8, 3,10,  0,24, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[3 !B"},      6, 3,10,  6,10, 0,   0,    0,   0));
        vt.push_back(mk({8'h1B, "[2f"},        4, 3,10,  1, 0, 0,   0,    0,   0));

        // Reset values while rst is held.
        @(negedge clk100);
        check("reset_outputs",
              {char_ready, overflow, wr_start, wr_begin, wr_end, wr_data, wr_offset, cur_row, cur_col},
              {1'b1, 53'd0});
        tick();
        rst = 1'b0;

        // Table-driven single-command / cursor vectors.
        foreach (vt[k]) begin
            v = vt[k];
            do_reset();
            goto_rc(v.sr, v.sc);
            if (v.cmd) exp_q.push_back(v.c);
            base = n_cmds;
            for (int i = 0; i < v.n; i++) send(v.msg[(v.n - 1 - i) * 8 +: 8]);
            if (v.cmd) begin
                wait_cmd(base + 1, $sformatf("v%0d", k));
                @(negedge clk100);
                check($sformatf("v%0d_ready_busy", k), 64'(char_ready), 64'd0);
                pulse_complete();
                @(negedge clk100);
                check($sformatf("v%0d_ready_after", k), 64'(char_ready), 64'd1);
            end else begin
                repeat (4) @(negedge clk100);
            end
            check($sformatf("v%0d_cursor", k), {cur_row, cur_col}, {6'(v.er), 7'(v.ec)});
            check($sformatf("v%0d_cmd_count", k), 64'(n_cmds - base), 64'(v.cmd ? 1 : 0));
        end

        // Line feed on the last row: scroll copy, then bottom-line clear.
        do_reset();
        goto_rc(24, 5);
        exp_q.push_back(mkc(0, 1920, 0, 80));
        exp_q.push_back(mkc(1920, 2000, 0, 0));
        base = n_cmds;
        send(8'h0A);
        wait_cmd(base + 1, "lf_scroll");
        @(negedge clk100);
        check("lf_ready_busy", 64'(char_ready), 64'd0);
        pulse_complete();
        wait_cmd(base + 2, "lf_clear");
        pulse_complete();
        @(negedge clk100);
        check("lf_ready_after", 64'(char_ready), 64'd1);
        check("lf_cursor", {cur_row, cur_col}, {6'd24, 7'd5});

        // Write at the bottom-right corner: write, wrap-scroll, clear,
        // plus a byte offered mid-command that must be dropped.
        do_reset();
        goto_rc(24, 79);
        exp_q.push_back(mkc(1999, 2000, 8'h51, 0));
        exp_q.push_back(mkc(0, 1920, 0, 80));
        exp_q.push_back(mkc(1920, 2000, 0, 0));
        base = n_cmds;
        send(8'h51);
        wait_cmd(base + 1, "corner_write");
        send(8'h52);
        @(negedge clk100);
        check("overflow_pulse", 64'(overflow), 64'd1);
        @(negedge clk100);
        check("overflow_one_cycle", 64'(overflow), 64'd0);
        pulse_complete();
        wait_cmd(base + 2, "corner_scroll");
        pulse_complete();
        wait_cmd(base + 3, "corner_clear");
        pulse_complete();
        repeat (4) @(negedge clk100);
        check("corner_cursor", {cur_row, cur_col}, {6'd24, 7'd0});
        check("corner_cmd_count", 64'(n_cmds - base), 64'd3);

        // Reset while the scroll copy is in flight abandons the clear.
        do_reset();
        goto_rc(24, 5);
        exp_q.push_back(mkc(0, 1920, 0, 80));
        base = n_cmds;
        send(8'h0A);
        wait_cmd(base + 1, "rst_scroll");
        tick();
        rst = 1'b1;
        @(negedge clk100);
        check("rst_mid_outputs",
              {char_ready, wr_start, wr_begin, wr_end, wr_offset, cur_row, cur_col},
              {1'b1, 44'd0});
        tick();
        rst = 1'b0;
        pulse_complete();
        repeat (10) @(negedge clk100);
        check("rst_mid_no_clear", 64'(n_cmds - base), 64'd1);
        check("rst_mid_cursor", {cur_row, cur_col}, {6'd0, 7'd0});
        check("rst_mid_ready", 64'(char_ready), 64'd1);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
